bin_to_gray_enc: RTL and testbench

//  Streaming binary-to-Gray encoder; the encode side paired with our Gray-to-binary decoder.

---
 rtl/gray_pkg.sv | 17 +
 rtl/bin_to_gray_enc_if.sv | 8 +
 rtl/gray_skid_buf.sv | 40 ++++
 rtl/bin_to_gray_enc.sv | 42 ++++
 tb/tb_bin_to_gray_enc.sv | 133 +++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and skid-buffer state type
package gray_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } gray_skid_st_t;
    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [63:0] gray2bin(input logic [63:0] g);
        logic [63:0] b;
        b[63] = g[63];
        for (int i = 62; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/bin_to_gray_enc_if.sv
// bin_to_gray_enc_if: valid/ready word stream
interface bin_to_gray_enc_if #(parameter int W = 8);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    modport master(output data, output valid, input ready);
    modport slave(input data, input valid, output ready);
endinterface

// File: rtl/gray_skid_buf.sv
// gray_skid_buf: 2-entry valid/ready skid buffer; state bits double as valid and full flags
module gray_skid_buf import gray_pkg::*; #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    gray_skid_st_t st, st_nx;
    logic [W-1:0] data_q, skid_q;
    logic in_x, out_x, load_out, load_skid;
    assign out_valid = st[0];
    assign in_ready  = !st[1];
    assign out_data  = data_q;
    assign in_x      = in_valid && in_ready;
    assign out_x     = out_valid && out_ready;
    always_comb begin
        st_nx     = st == ST_EMPTY ? (in_x ? ST_ONE : ST_EMPTY) :
                    st == ST_ONE   ? (in_x && !out_x ? ST_FULL : out_x && !in_x ? ST_EMPTY : ST_ONE) :
                                     (out_x ? ST_ONE : ST_FULL);
        load_out  = st == ST_FULL ? out_x : in_x && (st == ST_EMPTY || out_x);
        load_skid = st == ST_ONE && in_x && !out_x;
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            st     <= ST_EMPTY;
            data_q <= '0;
            skid_q <= '0;
        end else begin
            st <= st_nx;
            if (load_out) data_q <= st == ST_FULL ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
        end
    end
endmodule

// File: rtl/bin_to_gray_enc.sv
// bin_to_gray_enc: streaming binary-to-Gray encoder with skid buffer; BIN_TO_GRAY_PARITY_EN adds o_par
module bin_to_gray_enc import gray_pkg::*; #(
    parameter int NBIT  = 8,
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    bin_to_gray_enc_if.slave  bin,
    bin_to_gray_enc_if.master gray,
`ifdef BIN_TO_GRAY_PARITY_EN
    output logic              o_par,
`endif
    output logic [CNT_W-1:0]  o_cnt
);
    logic [NBIT-1:0] g;
    assign g = NBIT'(bin2gray(64'(bin.data)));
`ifdef BIN_TO_GRAY_PARITY_EN
    localparam int W = NBIT + 1;
    logic [W-1:0] d, q;
    assign d = {^g, g};
    assign {o_par, gray.data} = q;
`else
    localparam int W = NBIT;
    logic [W-1:0] d, q;
    assign d = g;
    assign gray.data = q;
`endif
    gray_skid_buf #(.W(W)) u_buf (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .in_data   (d),
        .in_valid  (bin.valid),
        .in_ready  (bin.ready),
        .out_data  (q),
        .out_valid (gray.valid),
        .out_ready (gray.ready)
    );
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) o_cnt <= '0;
        else if (gray.valid && gray.ready) o_cnt <= o_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_bin_to_gray_enc.sv
// tb_bin_to_gray_enc: directed and random checks of bin_to_gray_enc against a queue model
module tb_bin_to_gray_enc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] o_cnt;
`ifdef BIN_TO_GRAY_PARITY_EN
    logic o_par;
`endif
    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic [15:0] cnt = 16'd0;
    int sent = 0;
    bin_to_gray_enc_if #(.W(8)) bin_if ();
    bin_to_gray_enc_if #(.W(8)) gray_if ();
    bin_to_gray_enc #(.NBIT(8), .CNT_W(16)) dut (
        .i_clk  (clk),
        .i_rstn (rst_n),
        .bin    (bin_if.slave),
        .gray   (gray_if.master),
`ifdef BIN_TO_GRAY_PARITY_EN
        .o_par  (o_par),
`endif
        .o_cnt  (o_cnt)
    );
    initial forever #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // called at a falling edge: drive, predict transfers, clock, then check against the queue
    task automatic step(input logic v, input logic [7:0] b, input logic r);
        logic in_x, out_x, stall;
        logic [7:0] g0, e;
        bin_if.valid = v;
        bin_if.data = b;
        gray_if.ready = r;
        in_x = v && bin_if.ready;
        out_x = gray_if.valid && r;
        stall = gray_if.valid && !r;
        g0 = gray_if.data;
        @(posedge clk);
        if (out_x) begin
            void'(q.pop_front());
            cnt++;
        end
        if (in_x) begin
            q.push_back(b);
            sent++;
        end
        @(negedge clk);
        chk("valid", 32'(gray_if.valid), 32'(q.size() != 0));
        chk("ready", 32'(bin_if.ready), 32'(q.size() < 2));
        chk("cnt", 32'(o_cnt), 32'(cnt));
        if (q.size() != 0) begin
            e = q[0] ^ (q[0] >> 1);
            chk("gray", 32'(gray_if.data), 32'(e));
`ifdef BIN_TO_GRAY_PARITY_EN
            chk("par", 32'(o_par), 32'(^e));
`endif
        end
        if (stall) chk("stall", 32'(gray_if.data), 32'(g0));
    endtask
    initial begin
        logic [7:0] seq_in[5];
        logic [7:0] seq_out[5];
        logic [7:0] prev;
        int cyc;
        seq_in  = '{8'h00, 8'h05, 8'h80, 8'h7F, 8'hFF};
        seq_out = '{8'h00, 8'h07, 8'hC0, 8'h40, 8'h80};
        bin_if.valid = 1'b0;
        bin_if.data = 8'h00;
        gray_if.ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(gray_if.valid), 32'd0);
        chk("rst_ready", 32'(bin_if.ready), 32'd1);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        chk("rst_gray", 32'(gray_if.data), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq_in[i], 1'b1);
            chk("b2b_gray", 32'(gray_if.data), 32'(seq_out[i]));
        end
        step(1'b0, 8'h00, 1'b1);
        chk("b2b_cnt", 32'(o_cnt), 32'd5);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        chk("stall_full", 32'(bin_if.ready), 32'd0);
        step(1'b1, 8'h03, 1'b0);
        chk("stall_hold", 32'(gray_if.data), 32'h01);
        step(1'b1, 8'h03, 1'b1);
        chk("stall_second", 32'(gray_if.data), 32'h03);
        step(1'b1, 8'h03, 1'b1);
        chk("stall_third", 32'(gray_if.data), 32'h02);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'(i), 1'b1);
            if (i > 0) chk("adj_bits", 32'($countones(prev ^ gray_if.data)), 32'd1);
            prev = gray_if.data;
        end
        step(1'b0, 8'h00, 1'b1);
        sent = 0;
        cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
            cyc++;
        end
        chk("rand_budget", 32'(sent), 32'd10000);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        chk("pre_rst_full", 32'(bin_if.ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(gray_if.valid), 32'd0);
        chk("arst_ready", 32'(bin_if.ready), 32'd1);
        chk("arst_cnt", 32'(o_cnt), 32'd0);
        q.delete();
        cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h5A, 1'b1);
        chk("post_rst_gray", 32'(gray_if.data), 32'h77);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_cnt", 32'(o_cnt), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
